// File: rtl/array_div_pkg.sv
// Shared types and default sizes for the array divider sequencer.
// Default geometry matches the matrix-inverse row: six lanes of 27-bit words.
// The divider latency default is the fixed pipeline depth of the array divider.
package array_div_pkg;

    localparam int N   = 6;
    localparam int W   = 27;
    localparam int LAT = 27;

    typedef logic [W-1:0] word_t;
    typedef word_t [N-1:0] row_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CLR  = 2'd1,
        RUN  = 2'd2,
        DONE = 2'd3
    } ctrl_state_e;

endpackage

// File: rtl/array_div_ctrl.sv
// Sequences one row job through the array divider: clear, run LAT cycles, capture quotients.
// Latency: LAT+2 cycles from acceptance to out_valid; one job in flight, spacing >= LAT+3.
// Backpressure: in_ready only in IDLE; the result is held in DONE until out_ready.
module array_div_ctrl #(
    parameter int N   = array_div_pkg::N,
    parameter int W   = array_div_pkg::W,
    parameter int LAT = array_div_pkg::LAT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [N-1:0][W-1:0]   in_dividends,
    input  logic [W-1:0]          in_divisor,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [N-1:0][W-1:0]   out_quotients,
    output logic                  out_div0,
    output logic                  div_en,
    output logic                  div_rst,
    output logic [N-1:0][W-1:0]   div_dividends,
    output logic [W-1:0]          div_divisor,
    input  logic [N-1:0][W-1:0]   div_quotients
);

    import array_div_pkg::ctrl_state_e;
    import array_div_pkg::IDLE;
    import array_div_pkg::CLR;
    import array_div_pkg::RUN;
    import array_div_pkg::DONE;

    // LAT=1 still needs a one-bit counter; it is loaded with 0 so RUN lasts one cycle.
    localparam int            CW       = (LAT > 1) ? $clog2(LAT) : 1;
    localparam logic [CW-1:0] CNT_LOAD = CW'(LAT - 1);

    ctrl_state_e          state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [N-1:0][W-1:0]  opnd_q, opnd_d;
    logic [W-1:0]         dvsr_q, dvsr_d;
    logic                 div0_q, div0_d;
    logic [N-1:0][W-1:0]  quot_q, quot_d;
    logic                 out_div0_q, out_div0_d;

    assign div_dividends = opnd_q;
    assign div_divisor   = dvsr_q;
    assign out_quotients = quot_q;
    assign out_div0      = out_div0_q;

    // Next-state, counter and capture logic; handshake and divider controls decode from state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        opnd_d     = opnd_q;
        dvsr_d     = dvsr_q;
        div0_d     = div0_q;
        quot_d     = quot_q;
        out_div0_d = out_div0_q;
        in_ready   = 1'b0;
        out_valid  = 1'b0;
        div_en     = 1'b0;
        div_rst    = 1'b0;

        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    opnd_d  = in_dividends;
                    dvsr_d  = in_divisor;
                    div0_d  = (in_divisor == '0);
                    state_d = CLR;
                end
            end
            CLR: begin
                div_rst = 1'b1;
                cnt_d   = CNT_LOAD;
                state_d = RUN;
            end
            RUN: begin
                div_en = 1'b1;
                if (cnt_q == '0) begin
                    // A zero divisor runs the full sequence; only the captured value is forced.
                    quot_d     = div0_q ? '0 : div_quotients;
                    out_div0_d = div0_q;
                    state_d    = DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low clear.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            opnd_q     <= '0;
            dvsr_q     <= '0;
            div0_q     <= 1'b0;
            quot_q     <= '0;
            out_div0_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            opnd_q     <= opnd_d;
            dvsr_q     <= dvsr_d;
            div0_q     <= div0_d;
            quot_q     <= quot_d;
            out_div0_q <= out_div0_d;
        end
    end

endmodule
